action_encoder: RTL and testbench



---
 rtl/action_encoder.sv | 209 ++++++++++++++++++++
 tb/tb_action_encoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/action_encoder.sv
// -----------------------------------------------------------------------------
// action_encoder
//
// Source end of the player action interface. Collects block/reload/shoot
// button presses during a fixed round window and issues one one-hot action
// per round to the bullet counter. The chosen action is legalised against the
// bullet count, so the counter is never handed a move it would have to ignore.
//
// Action encoding: 001 block, 010 reload, 100 shoot, 000 no action.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   start          level; begins rounds when idle
//   stop           level; ends the match and returns to idle (wins over start)
//   btn_block      block button, active-high
//   btn_reload     reload button, active-high
//   btn_shoot      shoot button, active-high
//   num_bullets    bullet count fed back from the bullet counter (0..3)
//   action         one-hot action, non-zero only in the COMMIT cycle
//   round_tick     1-cycle pulse coincident with action
//   choice_locked  a press has been captured in the current round
//   round_active   high in COLLECT and COMMIT
//
// Optional feature (macro ACTION_SYNC_EN):
//   defined   - each button passes through a 2-flop synchroniser before edge
//               detection (button-to-capture latency 3 cycles); an edge that
//               reaches the detector in COMMIT is carried into the next round.
//   undefined - buttons are synchronous to clk, one edge-detect register per
//               button (button-to-capture latency 1 cycle).
//
// State table
//   IDLE    | waiting for start; timer and choice held at 0
//   COLLECT | round window open, timer counting, first press locks the choice
//   COMMIT  | single cycle issuing the legalised action and round_tick
// -----------------------------------------------------------------------------
module action_encoder #(
  parameter int ROUND_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       btn_block,
  input  logic       btn_reload,
  input  logic       btn_shoot,
  input  logic [1:0] num_bullets,
  output logic [2:0] action,
  output logic       round_tick,
  output logic       choice_locked,
  output logic       round_active
);

  localparam int TW = $clog2(ROUND_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ROUND_CYCLES - 1);

  localparam logic [2:0] ACT_NONE   = 3'b000;
  localparam logic [2:0] ACT_BLOCK  = 3'b001;
  localparam logic [2:0] ACT_RELOAD = 3'b010;
  localparam logic [2:0] ACT_SHOOT  = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      choice_q, choice_d;

  // Button vector uses the same bit positions as the action encoding.
  logic [2:0] btn_raw;
  logic [2:0] btn_det;
  logic [2:0] btn_prev_q;
  logic [2:0] rise;
  logic [2:0] press_enc;
  logic [2:0] choice_eff;
  logic [2:0] choice_legal;

  assign btn_raw = {btn_shoot, btn_reload, btn_block};

`ifdef ACTION_SYNC_EN
  logic [2:0] btn_sync1_q;
  logic [2:0] btn_sync2_q;

  // Synchroniser and edge register all preload with the raw levels so a
  // button held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync1_q <= btn_raw;
      btn_sync2_q <= btn_raw;
      btn_prev_q  <= btn_raw;
    end else begin
      btn_sync1_q <= btn_raw;
      btn_sync2_q <= btn_sync1_q;
      btn_prev_q  <= btn_sync2_q;
    end
  end

  assign btn_det = btn_sync2_q;
`else
  always_ff @(posedge clk) begin
    btn_prev_q <= btn_raw;
  end

  assign btn_det = btn_raw;
`endif

  assign rise = btn_det & ~btn_prev_q;

  // Simultaneous edges resolve block > shoot > reload.
  always_comb begin
    press_enc = ACT_NONE;
    if (rise[0]) begin
      press_enc = ACT_BLOCK;
    end else if (rise[2]) begin
      press_enc = ACT_SHOOT;
    end else if (rise[1]) begin
      press_enc = ACT_RELOAD;
    end
  end

  // Unpressed rounds default to block; moves the counter cannot honour
  // (shoot on empty, reload when full) are downgraded to block.
  always_comb begin
    choice_eff   = (choice_q == ACT_NONE) ? ACT_BLOCK : choice_q;
    choice_legal = choice_eff;
    if (choice_eff == ACT_SHOOT && num_bullets == 2'd0) begin
      choice_legal = ACT_BLOCK;
    end else if (choice_eff == ACT_RELOAD && num_bullets == 2'd3) begin
      choice_legal = ACT_BLOCK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      choice_q <= ACT_NONE;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      choice_q <= choice_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    choice_d   = choice_q;
    action     = ACT_NONE;
    round_tick = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d  = '0;
        choice_d = ACT_NONE;
        if (start && !stop) begin
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (stop) begin
          state_d  = IDLE;
          timer_d  = '0;
          choice_d = ACT_NONE;
        end else begin
          timer_d = timer_q + TW'(1);
          if (choice_q == ACT_NONE) begin
            choice_d = press_enc;
          end
          if (timer_q == TIMER_LAST) begin
            state_d = COMMIT;
            timer_d = '0;
          end
        end
      end

      COMMIT: begin
        action     = choice_legal;
        round_tick = 1'b1;
        timer_d    = '0;
        choice_d   = ACT_NONE;
        if (stop) begin
          state_d = IDLE;
        end else begin
          state_d = COLLECT;
`ifdef ACTION_SYNC_EN
          // The synchroniser delays edges; one landing here belongs to the
          // round that opens next cycle rather than being lost.
          choice_d = press_enc;
`endif
        end
      end

      default: begin
        state_d  = IDLE;
        timer_d  = '0;
        choice_d = ACT_NONE;
      end
    endcase
  end

  assign choice_locked = (choice_q != ACT_NONE);
  assign round_active  = (state_q != IDLE);

endmodule

// File: tb/tb_action_encoder.sv
module tb_action_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       btn_block;
  logic       btn_reload;
  logic       btn_shoot;
  logic [1:0] num_bullets;
  logic [2:0] action;
  logic       round_tick;
  logic       choice_locked;
  logic       round_active;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  action_encoder #(.ROUND_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .btn_block     (btn_block),
    .btn_reload    (btn_reload),
    .btn_shoot     (btn_shoot),
    .num_bullets   (num_bullets),
    .action        (action),
    .round_tick    (round_tick),
    .choice_locked (choice_locked),
    .round_active  (round_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_btn(input logic [2:0] b);
    {btn_shoot, btn_reload, btn_block} = b;
  endtask

  // Waits (bounded) for round_tick; checks cycles taken and the action.
  task automatic run_to_tick(input int exp_n, input logic [2:0] exp_act, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!round_tick && n < 30);
    chk({tag, "_period"}, n, exp_n);
    chk({tag, "_action"}, action, exp_act);
  endtask

  // Called at a COMMIT negedge. Button pattern a is set during COLLECT
  // cycle ca (9 = during COMMIT), pattern b during cycle cb.
  task automatic round(input logic [2:0] a, input int ca, input logic [2:0] b, input int cb,
                       input logic [1:0] nb, input logic [2:0] exp, input string tag);
    num_bullets = nb;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      set_btn((k == ca) ? a : (k == cb) ? b : 3'b000);
    end
    @(negedge clk);
    chk({tag, "_tick"}, round_tick, 1'b1);
    chk({tag, "_action"}, action, exp);
    set_btn((ca == 9) ? a : 3'b000);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    set_btn(3'b000);
    num_bullets = 2'd1;
    repeat (2) @(negedge clk);
    chk("rst_action", action, 3'b000);
    chk("rst_tick", round_tick, 1'b0);
    chk("rst_locked", choice_locked, 1'b0);
    chk("rst_active", round_active, 1'b0);

    rst = 1'b0;
    start = 1'b1;

`ifdef ACTION_SYNC_EN
    run_to_tick(9, 3'b001, "s_first");
    round(3'b100, 3, 3'b000, 0, 2'd2, 3'b100, "s_mid");
    round(3'b100, 8, 3'b000, 0, 2'd2, 3'b001, "s_late_press");
    round(3'b000, 0, 3'b000, 0, 2'd2, 3'b100, "s_carried");
    round(3'b000, 0, 3'b000, 0, 2'd2, 3'b001, "s_default");
`else
    run_to_tick(9, 3'b001, "first");
    @(negedge clk);
    chk("post_tick_action", action, 3'b000);
    chk("post_tick_tick", round_tick, 1'b0);
    run_to_tick(8, 3'b001, "second");

    @(negedge clk);
    @(negedge clk);
    set_btn(3'b010);
    chk("reload_unlocked_c2", choice_locked, 1'b0);
    @(negedge clk);
    set_btn(3'b000);
    chk("reload_locked_c3", choice_locked, 1'b1);
    run_to_tick(6, 3'b010, "reload");
    @(negedge clk);
    chk("locked_cleared", choice_locked, 1'b0);
    run_to_tick(8, 3'b001, "idle_round");

    round(3'b100, 3, 3'b000, 0, 2'd0, 3'b001, "shoot_nb0");
    round(3'b010, 3, 3'b000, 0, 2'd3, 3'b001, "reload_nb3");
    round(3'b100, 3, 3'b000, 0, 2'd2, 3'b100, "shoot_nb2");
    round(3'b010, 1, 3'b100, 4, 2'd1, 3'b010, "first_wins");
    round(3'b110, 2, 3'b000, 0, 2'd1, 3'b100, "shoot_over_reload");
    round(3'b111, 2, 3'b000, 0, 2'd1, 3'b001, "all_three");
    round(3'b000, 0, 3'b000, 0, 2'd0, 3'b001, "default_nb0");
    round(3'b010, 8, 3'b000, 0, 2'd0, 3'b010, "last_cycle_reload");
    round(3'b100, 9, 3'b000, 0, 2'd2, 3'b001, "press_in_commit");
    round(3'b000, 0, 3'b000, 0, 2'd2, 3'b001, "commit_edge_dropped");

    // stop during COLLECT cycle 5, with start still high
    repeat (5) @(negedge clk);
    chk("stop_c5_active", round_active, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    chk("stop_idle_active", round_active, 1'b0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (round_tick || round_active) seen++;
    end
    chk("stop_wins_over_start", seen, 0);
    stop = 1'b0;
    run_to_tick(9, 3'b001, "restart");

    // stop during COMMIT: action still issued
    repeat (8) @(negedge clk);
    @(negedge clk);
    stop = 1'b1;
    num_bullets = 2'd1;
    chk("stop_commit_tick", round_tick, 1'b1);
    chk("stop_commit_action", action, 3'b001);
    @(negedge clk);
    chk("stop_commit_idle", round_active, 1'b0);
    stop = 1'b0;

    // reset mid-round with a locked choice and shoot held through reset
    @(negedge clk);
    @(negedge clk);
    set_btn(3'b001);
    @(negedge clk);
    chk("pre_rst_locked", choice_locked, 1'b1);
    set_btn(3'b100);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outputs", {action, round_tick, choice_locked, round_active}, 6'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    num_bullets = 2'd2;
    run_to_tick(9, 3'b001, "held_through_rst");
    set_btn(3'b000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
